// File: rtl/level_pkg.sv
// Shared types and code constants for the game-level sequencer and the object-table select logic.
package level_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_TRANSITION = 3'd2,
    ST_END_WIN    = 3'd3,
    ST_END_LOSE   = 3'd4
  } state_t;

  localparam logic [1:0] LEVEL_ONE   = 2'b00;
  localparam logic [1:0] LEVEL_TWO   = 2'b01;
  localparam logic [1:0] LEVEL_TRANS = 2'b10;
  localparam logic [1:0] LEVEL_END   = 2'b11;

  localparam logic [1:0] BANNER_NONE = 2'd0;
  localparam logic [1:0] BANNER_NEXT = 2'd1;
  localparam logic [1:0] BANNER_WIN  = 2'd2;
  localparam logic [1:0] BANNER_LOSE = 2'd3;

  // Table-select code for a playable level index.
  function automatic logic [1:0] level_code(input logic idx);
    return idx ? LEVEL_TWO : LEVEL_ONE;
  endfunction

endpackage

// File: rtl/level_sequencer_rise_detect.sv
// Rising-edge detector with a history register that presets to 1, so a level held through reset never fires.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= d;
    end
  end

  assign rise = d & ~prev_reg;

endmodule

// File: rtl/level_sequencer.sv
// Game-level controller: IDLE -> level 1 -> banner -> level 2 -> win/lose, with lives, play gate and reload pulse.
module level_sequencer
  import level_pkg::*;
#(
  parameter int NUM_LEVELS        = 2,
  parameter int TRANSITION_FRAMES = 60,
  parameter int LIVES             = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       startKey,
  input  logic       levelDone,
  input  logic       playerDied,
  output logic [1:0] levelCode,
  output logic       levelLoad,
  output logic       playEnable,
  output logic [1:0] lives,
  output logic [1:0] bannerCode
);

  localparam int FCW = $clog2(TRANSITION_FRAMES + 1);

  state_t         state_reg;
  logic           level_idx_reg;
  logic [FCW-1:0] frame_cnt_reg;
  logic           key_rise;

  rise_detect u_key_rise (
    .clk   (clk),
    .reset (reset),
    .d     (startKey),
    .rise  (key_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      level_idx_reg <= 1'b0;
      frame_cnt_reg <= '0;
      levelCode     <= LEVEL_ONE;
      levelLoad     <= 1'b0;
      playEnable    <= 1'b0;
      lives         <= 2'(LIVES);
      bannerCode    <= BANNER_NONE;
    end else begin
      levelLoad <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_END_WIN, ST_END_LOSE: begin
          if (key_rise) begin
            state_reg     <= ST_PLAY;
            level_idx_reg <= 1'b0;
            lives         <= 2'(LIVES);
            levelCode     <= LEVEL_ONE;
            levelLoad     <= 1'b1;
            playEnable    <= 1'b1;
            bannerCode    <= BANNER_NONE;
          end
        end

        ST_PLAY: begin
          // A death in the same cycle as completion takes precedence.
          if (playerDied) begin
            if (lives > 2'd1) begin
              lives     <= lives - 2'd1;
              levelLoad <= 1'b1;
            end else begin
              lives      <= 2'd0;
              state_reg  <= ST_END_LOSE;
              levelCode  <= LEVEL_END;
              playEnable <= 1'b0;
              bannerCode <= BANNER_LOSE;
            end
          end else if (levelDone) begin
            playEnable <= 1'b0;
            if (32'(level_idx_reg) < NUM_LEVELS - 1) begin
              state_reg     <= ST_TRANSITION;
              frame_cnt_reg <= FCW'(TRANSITION_FRAMES - 1);
              levelCode     <= LEVEL_TRANS;
              bannerCode    <= BANNER_NEXT;
            end else begin
              state_reg  <= ST_END_WIN;
              levelCode  <= LEVEL_END;
              bannerCode <= BANNER_WIN;
            end
          end
        end

        ST_TRANSITION: begin
          if (startOfFrame) begin
            if (frame_cnt_reg == '0) begin
              state_reg     <= ST_PLAY;
              level_idx_reg <= level_idx_reg + 1'b1;
              levelCode     <= level_code(level_idx_reg + 1'b1);
              levelLoad     <= 1'b1;
              playEnable    <= 1'b1;
              bannerCode    <= BANNER_NONE;
            end else begin
              frame_cnt_reg <= frame_cnt_reg - 1'b1;
            end
          end
        end

        default: begin
          state_reg     <= ST_IDLE;
          level_idx_reg <= 1'b0;
          frame_cnt_reg <= '0;
          levelCode     <= LEVEL_ONE;
          playEnable    <= 1'b0;
          lives         <= 2'(LIVES);
          bannerCode    <= BANNER_NONE;
        end
      endcase
    end
  end

endmodule
